// File: rtl/wadd_arb_pkg.sv
// Shared types and reset constants for the wadd_arbiter write-port sequencer.
package wadd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2
  } state_t;

  localparam int N_REQ = 4;

  localparam logic [1:0] LAST_GRANT_RST = 2'd3;
  localparam int         ADDR_RST       = 0;
  localparam int         DATA_RST       = 0;

endpackage

// File: rtl/wadd_arbiter_rr_arbiter.sv
// Combinational 4-way round-robin picker: searches upward from last_grant+1, wrapping mod 4.
module rr_arbiter
  import wadd_arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [1:0]       i_last_grant,
  output logic [N_REQ-1:0] o_grant,
  output logic [1:0]       o_winner
);

  logic [1:0] w_idx;
  logic       w_found;

  always_comb begin
    o_grant  = '0;
    o_winner = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = i_last_grant + 2'(k + 1);
      if (!w_found && i_req[w_idx]) begin
        w_found         = 1'b1;
        o_winner        = w_idx;
        o_grant[w_idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wadd_arbiter.sv
// Round-robin write arbiter driving io_WADD with a setup cycle then a one-cycle write strobe.
// Optional sticky address-collision detection is built when WADD_ARB_COLLISION_EN is defined.
module wadd_arbiter
  import wadd_arb_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        io_req_valid,
  output logic [3:0]        io_req_ready,
  input  logic [ADDR_W-1:0] io_req_addr_0,
  input  logic [ADDR_W-1:0] io_req_addr_1,
  input  logic [ADDR_W-1:0] io_req_addr_2,
  input  logic [ADDR_W-1:0] io_req_addr_3,
  input  logic [DATA_W-1:0] io_req_data_0,
  input  logic [DATA_W-1:0] io_req_data_1,
  input  logic [DATA_W-1:0] io_req_data_2,
  input  logic [DATA_W-1:0] io_req_data_3,
  output logic [ADDR_W-1:0] io_WADD,
  output logic              io_WEN,
  output logic [DATA_W-1:0] io_WDATA,
  output logic              io_busy,
  output logic [1:0]        io_last_grant,
  output logic              io_collision
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wen;
  logic [1:0]        r_last_grant;

  logic [ADDR_W-1:0] w_addr [N_REQ];
  logic [DATA_W-1:0] w_data [N_REQ];
  logic [N_REQ-1:0]  w_grant;
  logic [1:0]        w_winner;
  logic              w_idle;
  logic              w_accept;

  assign w_addr[0] = io_req_addr_0;
  assign w_addr[1] = io_req_addr_1;
  assign w_addr[2] = io_req_addr_2;
  assign w_addr[3] = io_req_addr_3;
  assign w_data[0] = io_req_data_0;
  assign w_data[1] = io_req_data_1;
  assign w_data[2] = io_req_data_2;
  assign w_data[3] = io_req_data_3;

  rr_arbiter u_rr (
    .i_req        (io_req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_winner     (w_winner)
  );

  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle && (|io_req_valid);

  // Grant is only ever offered while idle, so at most one accept per transaction.
  assign io_req_ready  = w_idle ? w_grant : '0;
  assign io_WADD       = r_addr;
  assign io_WEN        = r_wen;
  assign io_WDATA      = r_wdata;
  assign io_busy       = !w_idle;
  assign io_last_grant = r_last_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_addr       <= ADDR_W'(ADDR_RST);
      r_data       <= DATA_W'(DATA_RST);
      r_wdata      <= DATA_W'(DATA_RST);
      r_wen        <= 1'b0;
      r_last_grant <= LAST_GRANT_RST;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr       <= w_addr[w_winner];
            r_data       <= w_data[w_winner];
            r_last_grant <= w_winner;
            r_state      <= SETUP;
          end
        end
        SETUP: begin
          // Write data is presented together with the strobe; address was set up a cycle earlier.
          r_wen   <= 1'b1;
          r_wdata <= r_data;
          r_state <= STROBE;
        end
        STROBE: begin
          r_wen   <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_wen   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef WADD_ARB_COLLISION_EN
  logic r_collision;
  logic w_coll_hit;

  always_comb begin
    w_coll_hit = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if ((2'(k) != w_winner) && io_req_valid[k] && (w_addr[k] == w_addr[w_winner]))
        w_coll_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_collision <= 1'b0;
    else if (w_accept && w_coll_hit)
      r_collision <= 1'b1;
  end

  assign io_collision = r_collision;
`else
  assign io_collision = 1'b0;
`endif

endmodule

// File: tb/tb_wadd_arbiter.sv
// Directed self-checking bench for wadd_arbiter; inputs change on the falling edge, outputs checked 1ns later.
module tb_wadd_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] valid;
  logic [3:0] ready;
  logic [1:0] addr0, addr1, addr2, addr3;
  logic [7:0] data0, data1, data2, data3;
  logic [1:0] wadd;
  logic       wen;
  logic [7:0] wdata;
  logic       busy;
  logic [1:0] last_grant;
  logic       collision;

  int n_checks;
  int n_fail;

`ifdef WADD_ARB_COLLISION_EN
  localparam logic COLL_EXP = 1'b1;
`else
  localparam logic COLL_EXP = 1'b0;
`endif

  wadd_arbiter #(.ADDR_W(2), .DATA_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_req_valid  (valid),
    .io_req_ready  (ready),
    .io_req_addr_0 (addr0),
    .io_req_addr_1 (addr1),
    .io_req_addr_2 (addr2),
    .io_req_addr_3 (addr3),
    .io_req_data_0 (data0),
    .io_req_data_1 (data1),
    .io_req_data_2 (data2),
    .io_req_data_3 (data3),
    .io_WADD       (wadd),
    .io_WEN        (wen),
    .io_WDATA      (wdata),
    .io_busy       (busy),
    .io_last_grant (last_grant),
    .io_collision  (collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while (busy !== 1'b0 && cnt < 8) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, cnt);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    valid = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid = 4'b0000;
    #1;
    n_checks++; if (wen !== 1'b0)        begin n_fail++; $display("FAIL rst_wen: got %b want 0", wen); end
    n_checks++; if (wadd !== 2'd0)       begin n_fail++; $display("FAIL rst_wadd: got %0d want 0", wadd); end
    n_checks++; if (wdata !== 8'h00)     begin n_fail++; $display("FAIL rst_wdata: got %h want 00", wdata); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (last_grant !== 2'd3) begin n_fail++; $display("FAIL rst_last_grant: got %0d want 3", last_grant); end
    n_checks++; if (collision !== 1'b0)  begin n_fail++; $display("FAIL rst_collision: got %b want 0", collision); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (ready !== 4'b0000)   begin n_fail++; $display("FAIL rst_ready_idle: got %b want 0000", ready); end
    n_checks++; if (last_grant !== 2'd3) begin n_fail++; $display("FAIL rst_release_last_grant: got %0d want 3", last_grant); end
    @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_write();
    logic [3:0] ctrl;
    @(negedge clk);
    addr0 = 2'd2; data0 = 8'hA5; valid = 4'b0001;
    #1;
    n_checks++; if (ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready_T: got %b want 0001", ready); end
    @(negedge clk);
    addr1 = 2'd0; data1 = 8'h3C; valid = 4'b0010;
    #1;
    n_checks++; if (wadd !== 2'd2)     begin n_fail++; $display("FAIL single_wadd_T1: got %0d want 2", wadd); end
    n_checks++; if (wen !== 1'b0)      begin n_fail++; $display("FAIL single_wen_T1: got %b want 0", wen); end
    n_checks++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL single_busy_T1: got %b want 1", busy); end
    n_checks++; if (ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_setup: got %b want 0000", ready); end
    @(negedge clk);
    #1;
    ctrl = wen ? (4'b0001 << wadd) : 4'b0000;
    n_checks++; if (wen !== 1'b1)       begin n_fail++; $display("FAIL single_wen_T2: got %b want 1", wen); end
    n_checks++; if (wdata !== 8'hA5)    begin n_fail++; $display("FAIL single_wdata_T2: got %h want a5", wdata); end
    n_checks++; if (ctrl !== 4'b0100)   begin n_fail++; $display("FAIL single_ctrl: got %b want 0100", ctrl); end
    n_checks++; if (last_grant !== 2'd0) begin n_fail++; $display("FAIL single_last_grant: got %0d want 0", last_grant); end
    n_checks++; if (ready !== 4'b0000)  begin n_fail++; $display("FAIL single_ready_strobe: got %b want 0000", ready); end
    @(negedge clk);
    #1;
    n_checks++; if (wen !== 1'b0)       begin n_fail++; $display("FAIL single_wen_T3: got %b want 0", wen); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL single_busy_T3: got %b want 0", busy); end
    n_checks++; if (wadd !== 2'd2)      begin n_fail++; $display("FAIL single_wadd_hold: got %0d want 2", wadd); end
    n_checks++; if (wdata !== 8'hA5)    begin n_fail++; $display("FAIL single_wdata_hold: got %h want a5", wdata); end
    n_checks++; if (ready !== 4'b0010)  begin n_fail++; $display("FAIL single_pending_ready: got %b want 0010", ready); end
    @(negedge clk);
    valid = 4'b0000;
    #1;
    wait_idle();
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_data;
    apply_reset();
    addr0 = 2'd0; addr1 = 2'd1; addr2 = 2'd2; addr3 = 2'd3;
    data0 = 8'h10; data1 = 8'h11; data2 = 8'h12; data3 = 8'h13;
    valid = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      #1;
      exp_data = 8'h10 + 8'(t % 4);
      n_checks++; if (ready !== (4'b0001 << (t % 4))) begin n_fail++; $display("FAIL rr_ready_%0d: got %b want %b", t, ready, 4'b0001 << (t % 4)); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_busy_gap_%0d: got %b want 0", t, busy); end
      @(negedge clk);
      if (t == 4) valid = 4'b0000;
      #1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rr_busy_setup_%0d: got %b want 1", t, busy); end
      @(negedge clk);
      #1;
      n_checks++; if (wen !== 1'b1 || wdata !== exp_data) begin n_fail++; $display("FAIL rr_write_%0d: got wen=%b data=%h want wen=1 data=%h", t, wen, wdata, exp_data); end
      @(negedge clk);
    end
    #1;
    wait_idle();
    n_checks++; if (collision !== 1'b0) begin n_fail++; $display("FAIL rr_no_collision: got %b want 0", collision); end
  endtask

  task automatic test_priority();
    @(negedge clk);
    valid = 4'b0010;
    @(negedge clk);
    valid = 4'b0000;
    #1;
    wait_idle();
    n_checks++; if (last_grant !== 2'd1) begin n_fail++; $display("FAIL prio_setup_last_grant: got %0d want 1", last_grant); end
    @(negedge clk);
    valid = 4'b0101;
    #1;
    n_checks++; if (ready !== 4'b0100) begin n_fail++; $display("FAIL prio_first_winner: got %b want 0100", ready); end
    @(negedge clk);
    valid = 4'b0001;
    #1;
    n_checks++; if (last_grant !== 2'd2) begin n_fail++; $display("FAIL prio_last_grant_2: got %0d want 2", last_grant); end
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++; if (ready !== 4'b0001) begin n_fail++; $display("FAIL prio_second_winner: got %b want 0001", ready); end
    @(negedge clk);
    valid = 4'b0000;
    #1;
    n_checks++; if (last_grant !== 2'd0) begin n_fail++; $display("FAIL prio_last_grant_wrap: got %0d want 0", last_grant); end
    wait_idle();
  endtask

  task automatic test_collision();
    @(negedge clk);
    addr0 = 2'd3; addr1 = 2'd1; addr2 = 2'd2; addr3 = 2'd1;
    data0 = 8'h5A; data1 = 8'h21; data3 = 8'h23;
    valid = 4'b1010;
    #1;
    n_checks++; if (ready !== 4'b0010) begin n_fail++; $display("FAIL coll_winner: got %b want 0010", ready); end
    @(negedge clk);
    valid = 4'b1000;
    #1;
    n_checks++; if (collision !== COLL_EXP) begin n_fail++; $display("FAIL coll_flag_T1: got %b want %b", collision, COLL_EXP); end
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++; if (ready !== 4'b1000) begin n_fail++; $display("FAIL coll_second_winner: got %b want 1000", ready); end
    @(negedge clk);
    valid = 4'b0000;
    #1;
    wait_idle();
    @(negedge clk);
    valid = 4'b0001;
    @(negedge clk);
    valid = 4'b0000;
    #1;
    wait_idle();
    n_checks++; if (collision !== COLL_EXP) begin n_fail++; $display("FAIL coll_sticky: got %b want %b", collision, COLL_EXP); end
    n_checks++; if (wdata !== 8'h5A || wadd !== 2'd3) begin n_fail++; $display("FAIL coll_clean_write: got addr=%0d data=%h want addr=3 data=5a", wadd, wdata); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    addr0 = 2'd1; data0 = 8'h77; valid = 4'b0001;
    @(negedge clk);
    valid = 4'b0000;
    @(negedge clk);
    #1;
    n_checks++; if (wen !== 1'b1) begin n_fail++; $display("FAIL mid_strobe_wen: got %b want 1", wen); end
    reset = 1'b1;
    #1;
    n_checks++; if (wen !== 1'b0)        begin n_fail++; $display("FAIL mid_wen_drop: got %b want 0", wen); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_checks++; if (wadd !== 2'd0)       begin n_fail++; $display("FAIL mid_wadd: got %0d want 0", wadd); end
    n_checks++; if (last_grant !== 2'd3) begin n_fail++; $display("FAIL mid_last_grant: got %0d want 3", last_grant); end
    n_checks++; if (collision !== 1'b0)  begin n_fail++; $display("FAIL mid_collision: got %b want 0", collision); end
    @(negedge clk);
    reset = 1'b0;
    valid = 4'b1001;
    #1;
    n_checks++; if (ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first_after_reset: got %b want 0001", ready); end
    @(negedge clk);
    valid = 4'b0000;
    #1;
    wait_idle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    valid = 4'b0000;
    addr0 = '0; addr1 = '0; addr2 = '0; addr3 = '0;
    data0 = '0; data1 = '0; data2 = '0; data3 = '0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_priority();
    test_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
